// File: rtl/uart_tx_fifo.sv
// UART transmitter with a circular transmit FIFO; frames go out back-to-back
// while words are queued, with bit timing taken from an external baud tick.
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              tx,
    output logic              busy,
    output logic              tx_done,
    output logic [CW-1:0]     fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;
    logic [IW-1:0]     bit_idx;
    logic              stop_cnt;
    logic              wr_en;
    logic              last_stop;
    logic              pop;

    assign wr_en      = wr_valid && wr_ready;
    assign last_stop  = (stop_cnt == 1'(STOP_BITS - 1));
    assign pop        = baud_tick && (count != '0) &&
                        ((state == IDLE) || ((state == STOP) && last_stop));
    assign fifo_count = count;

    always_comb begin
        count_next = count;
        case ({wr_en, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Storage is not reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            wr_ready <= 1'b1;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count    <= count_next;
            wr_ready <= (count_next != CW'(FIFO_DEPTH));
        end
    end

    // Parity is captured at load time because the shift register is consumed
    // bit by bit during the data phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (baud_tick) begin
                case (state)
                    IDLE: begin
                        if (count != '0) begin
                            shreg   <= mem[rd_ptr];
                            par_bit <= (^mem[rd_ptr]) ^ (PARITY == 2);
                            tx      <= 1'b0;
                            busy    <= 1'b1;
                            state   <= START;
                        end else begin
                            tx <= 1'b1;
                        end
                    end
                    START: begin
                        tx      <= shreg[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                    DATA: begin
                        if (bit_idx < IW'(DATA_W - 1)) begin
                            tx      <= shreg[1];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + IW'(1);
                        end else if (PARITY != 0) begin
                            tx    <= par_bit;
                            state <= PAR;
                        end else begin
                            tx       <= 1'b1;
                            stop_cnt <= 1'b0;
                            state    <= STOP;
                        end
                    end
                    PAR: begin
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
                    STOP: begin
                        if (!last_stop) begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end else begin
                            tx_done <= 1'b1;
                            if (count != '0) begin
                                shreg   <= mem[rd_ptr];
                                par_bit <= (^mem[rd_ptr]) ^ (PARITY == 2);
                                tx      <= 1'b0;
                                state   <= START;
                            end else begin
                                tx    <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end
                    default: begin
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with a built-in transmit FIFO, the next generation of the team's fixed 8-bit transmitter. It serialises words of configurable width with optional even/odd parity and 1 or 2 stop bits, and transmits back-to-back frames without idle gaps while the FIFO holds data. It sits between a host write port and the serial line. Bit timing comes from the existing baud generator, presented as a one-cycle enable pulse in the same clock domain.

## Interface
- DATA_W, 8, data bits per frame, legal 5..9
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, legal 1 or 2
- FIFO_DEPTH, 4, power of two, at least 2; CW = log2(FIFO_DEPTH)+1
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- baud_tick  in  1  one-cycle pulse per bit period, from the baud generator
- wr_data  in  DATA_W  word to transmit
- wr_valid  in  1  write request
- wr_ready  out  1  high when the FIFO is not full; a write is accepted when wr_valid && wr_ready
- tx  out  1  serial line, idles high
- busy  out  1  high while the FSM is not in IDLE
- tx_done  out  1  one-cycle pulse when the last stop bit period ends
- fifo_count  out  CW  number of words held, 0..FIFO_DEPTH

## Operation
- Reset values: tx=1, busy=0, tx_done=0, fifo_count=0, wr_ready=1, FSM=IDLE, FIFO pointers=0.
- FIFO is circular, with read/write pointers that wrap at FIFO_DEPTH.
  - count +1 on an accepted write, -1 on a pop, unchanged when both occur in the same cycle.
  - A write while full is ignored and the FIFO contents are unchanged.
  - A pop happens only inside the FSM, only when count is nonzero.
- Frame format: start(0), data LSB first, parity if PARITY != 0, then STOP_BITS stop bits (1).
  - Frame length in ticks = 1 + DATA_W + (PARITY?1:0) + STOP_BITS.
- Parity bit: even = XOR of the data bits; odd = its inverse.
- FSM states are IDLE, START, DATA, PAR, STOP. State changes and tx updates happen only in cycles where baud_tick=1.
  - IDLE: tick and count>0 -> pop into the shift register, tx<=0, go to START. Otherwise hold tx=1.
  - START: tick -> tx<=d[0], bit_idx<=0, go to DATA.
  - DATA: on tick, if bit_idx<DATA_W-1, tx<=d[bit_idx+1] and bit_idx++. Otherwise tx<=parity and go to PAR if PARITY!=0, else tx<=1 and go to STOP with stop_cnt=0.
  - PAR: tick -> tx<=1, go to STOP, stop_cnt<=0.
  - STOP: on tick, if stop_cnt<STOP_BITS-1, stop_cnt++. Otherwise assert tx_done for that cycle, then:
    - if count>0: pop, tx<=0, go to START (back-to-back frame);
    - else go to IDLE.
- The shift register is loaded only on a pop, so wr_data changes never corrupt a frame in flight.

## Timing
- tx, busy, tx_done and wr_ready are registered. tx changes in the cycle after the baud_tick cycle.
- wr_ready = (count != FIFO_DEPTH), taken from registered count. A pop in the same cycle does not free a slot until the next cycle.
- A word written at cycle t is poppable from t+1. The start bit begins after the first baud_tick at or after t+1.
- tx_done pulses exactly once per frame. Frames that follow in the same STOP tick add zero idle ticks.
- Reset asserted mid-frame: all outputs return to reset values asynchronously, the FIFO is emptied, and the partial frame is abandoned.
- baud_tick during reset is ignored. The first tick after reset release is handled as an IDLE tick.

## Test plan
- 8N1, baud_tick every 10 clk, write 0x81 -> tx per tick 0,1,0,0,0,0,0,0,1,1, then idle high; tx_done one pulse; busy high for 10 ticks.
- PARITY=1 then PARITY=2, data 0x81 -> parity bit 0 (even) and 1 (odd); 11-tick frame.
- DATA_W=5, STOP_BITS=2, write 0x13 -> 0,1,1,0,0,1,1,1; tx_done after the second stop tick.
- FIFO_DEPTH=4, hold baud_tick low, write 0x11,0x22,0x33,0x44,0x55 -> fifo_count=4, wr_ready=0, 0x55 dropped. Enable ticks -> four contiguous frames with no idle tick, fifo_count decrementing to 0.
- Write while a pop occurs with count=FIFO_DEPTH-1 -> count unchanged, data order preserved.
- Assert rst during the DATA bit 3 -> tx=1, fifo_count=0, busy=0 immediately. After release and a new write, a clean frame is sent.
